xbar_sw: RTL and testbench

XBAR_SW -- requirements
Module: xbar_sw

---
 rtl/xbar_sw_pkg.sv | 19 +
 rtl/xbar_sw_out_stage.sv | 58 +++++
 rtl/xbar_sw.sv | 149 ++++++++++++++
 tb/tb_xbar_sw.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xbar_sw_pkg.sv
// Shared constants and types for the xbar_sw crossbar switch.
package xbar_sw_pkg;

    localparam int N_IN_DEF  = 4;
    localparam int N_OUT_DEF = 4;
    localparam int W_DEF     = 8;
    localparam int CFG_IDX_W = 4;

    typedef struct packed {
        logic                 en;
        logic [CFG_IDX_W-1:0] sel;
    } route_t;

    typedef enum logic {
        CFG_IDLE = 1'b0,
        CFG_PEND = 1'b1
    } cfg_state_t;

endpackage

// File: rtl/xbar_sw_out_stage.sv
// One crossbar output: registered data/valid plus the route register
// that selects which input feeds it.
module xbar_sw_out_stage
    import xbar_sw_pkg::*;
#(
    parameter int N_IN = N_IN_DEF,
    parameter int W    = W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_IN*W-1:0] in_data,
    input  logic [N_IN-1:0]   xfer,
    input  logic              out_ready,
    input  logic              route_we,
    input  route_t            route_wdata,
    input  logic              route_block,
    output logic [W-1:0]      out_data,
    output logic              out_valid,
    output route_t            route
);

    logic [W-1:0] sel_data;
    logic         sel_xfer;
    logic         load;

    always_comb begin
        sel_data = '0;
        sel_xfer = 1'b0;
        for (int i = 0; i < N_IN; i++) begin
            if (route.sel == CFG_IDX_W'(i)) begin
                sel_data = in_data[i*W +: W];
                sel_xfer = xfer[i];
            end
        end
        load = route.en & sel_xfer & ~route_block;
    end

    // A load from the old route may coincide with a route write; the new
    // route only takes effect from the following cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            route     <= '0;
        end else begin
            if (load) begin
                out_data  <= sel_data;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (route_we) begin
                route <= route_wdata;
            end
        end
    end

endmodule

// File: rtl/xbar_sw.sv
// N_IN x N_OUT crossbar with per-output route registers and safe route updates.
// Define XBAR_SW_ERR_EN to add the sticky ERR output for illegal route writes.
module xbar_sw
    import xbar_sw_pkg::*;
#(
    parameter int N_IN  = N_IN_DEF,
    parameter int N_OUT = N_OUT_DEF,
    parameter int W     = W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_IN*W-1:0]    in_data,
    input  logic [N_IN-1:0]      in_valid,
    output logic [N_IN-1:0]      in_ready,
    output logic [N_OUT*W-1:0]   out_data,
    output logic [N_OUT-1:0]     out_valid,
    input  logic [N_OUT-1:0]     out_ready,
    input  logic                 cfg_we,
    input  logic [CFG_IDX_W-1:0] cfg_port,
    input  logic [CFG_IDX_W-1:0] cfg_sel,
    input  logic                 cfg_en,
    output logic                 cfg_ready
`ifdef XBAR_SW_ERR_EN
    ,
    output logic                 err
`endif
);

    localparam logic [CFG_IDX_W:0] N_IN_L  = (CFG_IDX_W+1)'(N_IN);
    localparam logic [CFG_IDX_W:0] N_OUT_L = (CFG_IDX_W+1)'(N_OUT);

    cfg_state_t           state;
    logic [CFG_IDX_W-1:0] pend_port;
    route_t               pend_route;
    route_t               route [N_OUT];
    route_t               route_wdata;
    logic [N_OUT-1:0]     can_acc;
    logic [N_OUT-1:0]     acc_ok;
    logic [N_OUT-1:0]     route_we;
    logic [N_OUT-1:0]     route_block;
    logic [N_IN-1:0]      routed;
    logic [N_IN-1:0]      stalled;
    logic [N_IN-1:0]      xfer;
    logic                 cfg_legal;
    logic                 cfg_hit_valid;
    logic                 pend_apply;

    assign can_acc   = ~out_valid | out_ready;
    assign cfg_legal = ({1'b0, cfg_port} < N_OUT_L) && ({1'b0, cfg_sel} < N_IN_L);

    // A pending route lands on the edge its output frees up; that output is
    // blocked from loading so no word is taken under the old route.
    always_comb begin
        route_we      = '0;
        route_block   = '0;
        cfg_hit_valid = 1'b0;
        pend_apply    = 1'b0;
        if (state == CFG_PEND) begin
            route_wdata = pend_route;
        end else begin
            route_wdata.en  = cfg_en;
            route_wdata.sel = cfg_sel;
        end
        for (int o = 0; o < N_OUT; o++) begin
            if (cfg_port == CFG_IDX_W'(o)) begin
                cfg_hit_valid = out_valid[o];
            end
            if (state == CFG_IDLE && cfg_we && cfg_legal &&
                cfg_port == CFG_IDX_W'(o) && !out_valid[o]) begin
                route_we[o] = 1'b1;
            end
            if (state == CFG_PEND && pend_port == CFG_IDX_W'(o) && can_acc[o]) begin
                route_we[o]    = 1'b1;
                route_block[o] = 1'b1;
                pend_apply     = 1'b1;
            end
        end
    end

    assign acc_ok = can_acc & ~route_block;

    always_comb begin
        routed  = '0;
        stalled = '0;
        for (int o = 0; o < N_OUT; o++) begin
            for (int i = 0; i < N_IN; i++) begin
                if (route[o].en && route[o].sel == CFG_IDX_W'(i)) begin
                    routed[i] = 1'b1;
                    if (!acc_ok[o]) begin
                        stalled[i] = 1'b1;
                    end
                end
            end
        end
    end

    assign in_ready = routed & ~stalled;
    assign xfer     = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= CFG_IDLE;
            cfg_ready  <= 1'b1;
            pend_port  <= '0;
            pend_route <= '0;
`ifdef XBAR_SW_ERR_EN
            err        <= 1'b0;
`endif
        end else if (state == CFG_IDLE) begin
            if (cfg_we && cfg_legal && cfg_hit_valid) begin
                pend_port      <= cfg_port;
                pend_route.en  <= cfg_en;
                pend_route.sel <= cfg_sel;
                state          <= CFG_PEND;
                cfg_ready      <= 1'b0;
            end
`ifdef XBAR_SW_ERR_EN
            if (cfg_we && !cfg_legal) begin
                err <= 1'b1;
            end
`endif
        end else begin
            if (pend_apply) begin
                state     <= CFG_IDLE;
                cfg_ready <= 1'b1;
            end
        end
    end

    for (genvar o = 0; o < N_OUT; o++) begin : g_out
        xbar_sw_out_stage #(
            .N_IN (N_IN),
            .W    (W)
        ) u_stage (
            .clk         (clk),
            .rst         (rst),
            .in_data     (in_data),
            .xfer        (xfer),
            .out_ready   (out_ready[o]),
            .route_we    (route_we[o]),
            .route_wdata (route_wdata),
            .route_block (route_block[o]),
            .out_data    (out_data[o*W +: W]),
            .out_valid   (out_valid[o]),
            .route       (route[o])
        );
    end

endmodule

// File: tb/tb_xbar_sw.sv
// Self-checking bench for xbar_sw: directed vector table, hand-written
// corner sequences and randomized traffic against a behavioural model.
module tb_xbar_sw;

    localparam int N_IN  = 4;
    localparam int N_OUT = 4;
    localparam int W     = 8;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [N_IN*W-1:0]    in_data;
    logic [N_IN-1:0]      in_valid;
    logic [N_IN-1:0]      in_ready;
    logic [N_OUT*W-1:0]   out_data;
    logic [N_OUT-1:0]     out_valid;
    logic [N_OUT-1:0]     out_ready;
    logic                 cfg_we;
    logic [3:0]           cfg_port;
    logic [3:0]           cfg_sel;
    logic                 cfg_en;
    logic                 cfg_ready;
`ifdef XBAR_SW_ERR_EN
    logic                 err;
`endif

    int checks = 0;
    int errors = 0;
    logic [N_IN-1:0] last_in_ready;
    bit model_on = 1'b0;

    always #5 clk = ~clk;

    xbar_sw #(.N_IN(N_IN), .N_OUT(N_OUT), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .cfg_we    (cfg_we),
        .cfg_port  (cfg_port),
        .cfg_sel   (cfg_sel),
        .cfg_en    (cfg_en),
        .cfg_ready (cfg_ready)
`ifdef XBAR_SW_ERR_EN
        ,
        .err       (err)
`endif
    );

    // Behavioural model: route table, output words and one pending route.
    bit                 m_en [N_OUT];
    int                 m_sel[N_OUT];
    logic [N_OUT-1:0]   m_valid;
    logic [N_OUT*W-1:0] m_data;
    bit                 m_pend;
    int                 m_pport;
    bit                 m_pen;
    int                 m_psel;

    function automatic void model_reset();
        for (int o = 0; o < N_OUT; o++) begin
            m_en[o]  = 1'b0;
            m_sel[o] = 0;
        end
        m_valid = '0;
        m_data  = '0;
        m_pend  = 1'b0;
        m_pport = 0;
        m_pen   = 1'b0;
        m_psel  = 0;
    endfunction

    function automatic logic [N_IN-1:0] model_ready();
        logic [N_IN-1:0] r;
        bit apply;
        bit any;
        bit blk;
        bit ok;
        apply = m_pend && (!m_valid[m_pport] || out_ready[m_pport]);
        for (int i = 0; i < N_IN; i++) begin
            any = 1'b0;
            blk = 1'b0;
            for (int o = 0; o < N_OUT; o++) begin
                if (m_en[o] && m_sel[o] == i) begin
                    any = 1'b1;
                    ok  = (!m_valid[o] || out_ready[o]) && !(apply && o == m_pport);
                    if (!ok) blk = 1'b1;
                end
            end
            r[i] = any && !blk;
        end
        return r;
    endfunction

    function automatic void model_step();
        logic [N_IN-1:0]  rdy;
        logic [N_OUT-1:0] nv;
        int s;
        if (rst) begin
            model_reset();
            return;
        end
        rdy = model_ready();
        nv  = m_valid;
        for (int o = 0; o < N_OUT; o++) begin
            s = m_sel[o];
            if (m_en[o] && in_valid[s] && rdy[s]) begin
                m_data[o*W +: W] = in_data[s*W +: W];
                nv[o] = 1'b1;
            end else if (out_ready[o]) begin
                nv[o] = 1'b0;
            end
        end
        if (!m_pend) begin
            if (cfg_we && int'(cfg_port) < N_OUT && int'(cfg_sel) < N_IN) begin
                if (!m_valid[cfg_port]) begin
                    m_en[cfg_port]  = cfg_en;
                    m_sel[cfg_port] = int'(cfg_sel);
                end else begin
                    m_pend  = 1'b1;
                    m_pport = int'(cfg_port);
                    m_pen   = cfg_en;
                    m_psel  = int'(cfg_sel);
                end
            end
        end else if (!m_valid[m_pport] || out_ready[m_pport]) begin
            m_en[m_pport]  = m_pen;
            m_sel[m_pport] = m_psel;
            m_pend         = 1'b0;
        end
        m_valid = nv;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One clock: compare against the model mid-cycle, then advance.
    task automatic tick();
        @(negedge clk);
        if (model_on) begin
            checkOutput("model in_ready",  32'(in_ready),  32'(model_ready()));
            checkOutput("model out_valid", 32'(out_valid), 32'(m_valid));
            checkOutput("model out_data",  out_data,       m_data);
            checkOutput("model cfg_ready", 32'(cfg_ready), 32'(!m_pend));
        end
        last_in_ready = in_ready;
        if (model_on) model_step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        rst;
        logic [3:0]  iv;
        logic [31:0] id;
        logic [3:0]  ordy;
        logic        we;
        logic [3:0]  port;
        logic [3:0]  sel;
        logic        en;
        logic [3:0]  exp_in_ready;
        logic [3:0]  exp_out_valid;
        logic [31:0] exp_out_data;
        logic        exp_cfg_ready;
        logic        exp_err;
    } vec_t;

    task automatic applyStimulus(input vec_t v);
        rst       = v.rst;
        in_valid  = v.iv;
        in_data   = v.id;
        out_ready = v.ordy;
        cfg_we    = v.we;
        cfg_port  = v.port;
        cfg_sel   = v.sel;
        cfg_en    = v.en;
    endtask

    task automatic idleInputs();
        rst = 1'b0; in_valid = '0; in_data = '0; out_ready = '0;
        cfg_we = 1'b0; cfg_port = '0; cfg_sel = '0; cfg_en = 1'b0;
    endtask

    task automatic writeRoute(input logic [3:0] port, input logic [3:0] sel);
        cfg_we = 1'b1; cfg_port = port; cfg_sel = sel; cfg_en = 1'b1;
        tick();
        cfg_we = 1'b0;
        checkOutput("route write cfg_ready", 32'(cfg_ready), 32'd1);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vec_t vecs[13];
        vecs[0]  = '{1'b1, 4'h0, 32'h00000000, 4'h0, 1'b0, 4'd0, 4'd0, 1'b0, 4'h0, 4'h0, 32'h00000000, 1'b1, 1'b0};
        vecs[1]  = '{1'b0, 4'h0, 32'h00000000, 4'hF, 1'b1, 4'd2, 4'd1, 1'b1, 4'h0, 4'h0, 32'h00000000, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 4'h2, 32'h00005A00, 4'hF, 1'b0, 4'd0, 4'd0, 1'b0, 4'h2, 4'h4, 32'h005A0000, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 4'h0, 32'h00000000, 4'hF, 1'b0, 4'd0, 4'd0, 1'b0, 4'h2, 4'h0, 32'h005A0000, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 4'h0, 32'h00000000, 4'hF, 1'b1, 4'd1, 4'd0, 1'b1, 4'h2, 4'h0, 32'h005A0000, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 4'h1, 32'h000000C3, 4'h0, 1'b0, 4'd0, 4'd0, 1'b0, 4'h3, 4'h2, 32'h005AC300, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 4'h0, 32'h00000000, 4'h0, 1'b1, 4'd1, 4'd3, 1'b1, 4'h2, 4'h2, 32'h005AC300, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 4'h0, 32'h00000000, 4'h0, 1'b1, 4'd2, 4'd0, 1'b0, 4'h2, 4'h2, 32'h005AC300, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 4'h1, 32'h000000EE, 4'h2, 1'b0, 4'd0, 4'd0, 1'b0, 4'h2, 4'h0, 32'h005AC300, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 4'h8, 32'h77000000, 4'hF, 1'b0, 4'd0, 4'd0, 1'b0, 4'hA, 4'h2, 32'h005A7700, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 4'h0, 32'h00000000, 4'hF, 1'b1, 4'd5, 4'd0, 1'b1, 4'hA, 4'h0, 32'h005A7700, 1'b1, 1'b1};
        vecs[11] = '{1'b0, 4'h0, 32'h00000000, 4'hF, 1'b1, 4'd0, 4'd9, 1'b1, 4'hA, 4'h0, 32'h005A7700, 1'b1, 1'b1};
        vecs[12] = '{1'b0, 4'hA, 32'h33004400, 4'hF, 1'b0, 4'd0, 4'd0, 1'b0, 4'hA, 4'h6, 32'h00443300, 1'b1, 1'b1};

        idleInputs();
        rst = 1'b1;
        tick();
        tick();
        model_reset();
        model_on = 1'b1;

        for (int k = 0; k < 13; k++) begin
            applyStimulus(vecs[k]);
            tick();
            checkOutput($sformatf("vec%0d in_ready", k),  32'(last_in_ready), 32'(vecs[k].exp_in_ready));
            checkOutput($sformatf("vec%0d out_valid", k), 32'(out_valid),     32'(vecs[k].exp_out_valid));
            checkOutput($sformatf("vec%0d out_data", k),  out_data,           vecs[k].exp_out_data);
            checkOutput($sformatf("vec%0d cfg_ready", k), 32'(cfg_ready),     32'(vecs[k].exp_cfg_ready));
`ifdef XBAR_SW_ERR_EN
            checkOutput($sformatf("vec%0d err", k),       32'(err),           32'(vecs[k].exp_err));
`endif
        end

        // Broadcast to o0 and o3 stalls until the slow output frees up.
        idleInputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        writeRoute(4'd0, 4'd2);
        writeRoute(4'd3, 4'd2);
        in_valid = 4'h4; in_data = 32'h00AB0000; out_ready = 4'h1;
        tick();
        checkOutput("bcast first in_ready", 32'(last_in_ready), 32'h4);
        checkOutput("bcast first out_valid", 32'(out_valid), 32'h9);
        checkOutput("bcast first out_data", out_data, 32'hAB0000AB);
        in_data = 32'h00110000;
        for (int k = 0; k < 2; k++) begin
            tick();
            checkOutput("bcast stall in_ready", 32'(last_in_ready), 32'h0);
            checkOutput("bcast stall out_valid", 32'(out_valid), 32'h8);
            checkOutput("bcast stall out_data", out_data, 32'hAB0000AB);
        end
        out_ready = 4'h9;
        tick();
        checkOutput("bcast release in_ready", 32'(last_in_ready), 32'h4);
        checkOutput("bcast release out_valid", 32'(out_valid), 32'h9);
        checkOutput("bcast release out_data", out_data, 32'h11000011);

        // Full-rate stream i0 -> o0, then reset in the middle of a second one.
        idleInputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        writeRoute(4'd0, 4'd0);
        out_ready = 4'hF;
        in_valid  = 4'h1;
        for (int k = 0; k < 256; k++) begin
            in_data = 32'(k);
            tick();
            checkOutput("stream out_valid", 32'(out_valid[0]), 32'd1);
            checkOutput("stream out_data", 32'(out_data[7:0]), 32'(k));
        end
        for (int k = 0; k < 50; k++) begin
            in_data = 32'(k);
            tick();
        end
        rst = 1'b1;
        tick();
        checkOutput("midstream reset out_valid", 32'(out_valid), 32'h0);
        checkOutput("midstream reset in_ready", 32'(in_ready), 32'h0);
        checkOutput("midstream reset out_data", out_data, 32'h0);
        rst = 1'b0;

        // Randomized traffic and route churn against the model.
        for (int k = 0; k < 2000; k++) begin
            rst       = ($urandom_range(0, 199) == 0);
            in_valid  = 4'($urandom());
            in_data   = $urandom();
            out_ready = ($urandom_range(0, 2) == 0) ? 4'($urandom()) : 4'hF;
            cfg_we    = ($urandom_range(0, 3) == 0);
            cfg_port  = 4'($urandom_range(0, 5));
            cfg_sel   = 4'($urandom_range(0, 5));
            cfg_en    = ($urandom_range(0, 4) != 0);
            tick();
        end
        idleInputs();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
